uart_tx_arbiter: RTL



---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the on-chip sources, the arbiter and uart_tx.
// The master side is the arbiter. The slave side is the environment, that is
// the requesters together with the serialiser.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;

  modport master (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

  modport slave (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx serialiser between NUM_REQ byte sources.
// A grant covers a whole message and is backed by a one-byte holding register.
//
// state | meaning
// IDLE  | no owner; arbitrate from last_grant+1 upward
// GRANT | grant_id owns the link; bytes move into the holding register
// DRAIN | message ended; wait for the held byte to leave, then release
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 8,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_tx_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam int SC_W = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t            state;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [BC_W-1:0]   burst_cnt;
  logic [SC_W-1:0]   stall_cnt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   next_grant;
  logic              found;
  logic              cur_valid;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;
  logic              accept;
  logic              tx_fire;

  assign cur_valid   = bus.req_valid[grant_id];
  assign cur_last    = bus.req_last[grant_id];
  assign cur_data    = bus.req_data[int'(grant_id)*DATA_W +: DATA_W];
  assign accept      = (state == GRANT) && !hold_valid && cur_valid;
  assign tx_fire     = hold_valid && bus.tx_ready;
  assign bus.tx_valid = hold_valid;
  assign bus.tx_data  = hold_data;
  assign busy         = (state != IDLE);

  // rotating-priority search starting just after the previous owner
  always_comb begin
    next_grant = last_grant;
    found      = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && bus.req_valid[(int'(last_grant) + i) % NUM_REQ]) begin
        next_grant = ID_W'((int'(last_grant) + i) % NUM_REQ);
        found      = 1'b1;
      end
    end
  end

  // accept only into an empty holding register; never looks at req_valid
  always_comb begin
    bus.req_ready = '0;
    if (state == GRANT && !hold_valid) bus.req_ready[grant_id] = 1'b1;
  end

  // grant FSM, holding register, burst and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      burst_cnt  <= '0;
      stall_cnt  <= '0;
      grant_id   <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      if (tx_fire) hold_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            grant_id  <= next_grant;
            burst_cnt <= '0;
            stall_cnt <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (accept) begin
            hold_data  <= cur_data;
            hold_valid <= 1'b1;
            burst_cnt  <= burst_cnt + 1'b1;
            stall_cnt  <= '0;
            if (cur_last || burst_cnt == BC_W'(MAX_BURST - 1)) state <= DRAIN;
          end else if (!hold_valid && !cur_valid) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == SC_W'(STALL_TIMEOUT - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!hold_valid || tx_fire) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
